// File: rtl/scan_sequencer_pkg.sv
// Shared types, constants and helpers for the digit scan sequencer.
package scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Counters are never narrower than one bit, even for a modulus of 1.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

    // First set mask bit after cur, searching cur+1, cur+2, cur+3, cur (mod 4).
    function automatic logic [1:0] next_digit(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = cur;
        for (int unsigned k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/display bundle between the scan sequencer and its driver.
interface scan_sequencer_if;
    logic       en;
    logic [3:0] mask;
    logic [1:0] S;
    logic       E;
    logic [3:0] an;
    logic       frame;

    modport master (output en, output mask, input S, input E, input an, input frame);
    modport slave  (input en, input mask, output S, output E, output an, output frame);
endinterface

// File: rtl/scan_sequencer_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, synchronous clear.
module tick_gen
    import scan_sequencer_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned W    = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/scan_sequencer.sv
// Four-digit 7-segment scan sequencer: digit select, mux enable, anodes, frame pulse.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic            clk,
    input  logic            rst,
    scan_sequencer_if.slave bus
);
    localparam int unsigned DMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned DW   = cnt_width(DMAX);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0] BLANK_LAST = (BLANK > 0) ? DW'(BLANK - 1) : '0;

    state_e        state_q, state_d;
    logic [1:0]    s_q, s_d;
    logic          e_q, e_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          seg_end;
    logic          tick;
    logic          clr;
    logic [1:0]    nxt;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign clr = (state_q == ST_IDLE) || seg_end;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        frame_d = 1'b0;
        dwell_d = dwell_q;
        seg_end = 1'b0;
        nxt     = next_digit(bus.mask, s_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.en && bus.mask != '0) begin
                    state_d = ST_SHOW;
                    s_d     = next_digit(bus.mask, 2'd3);
                    frame_d = 1'b1;
                    seg_end = 1'b1;
                end
            end
            ST_SHOW: begin
                // A digit dropped from the mask ends its dwell immediately.
                if (!bus.mask[s_q] || (tick && dwell_q == DWELL_LAST)) begin
                    seg_end = 1'b1;
                    if (BLANK == 0) begin
                        s_d     = nxt;
                        frame_d = (nxt <= s_q);
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else if (tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_BLANK: begin
                if (tick && dwell_q == BLANK_LAST) begin
                    seg_end = 1'b1;
                    state_d = ST_SHOW;
                    s_d     = nxt;
                    frame_d = (nxt <= s_q);
                end else if (tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                seg_end = 1'b1;
            end
        endcase

        if (!bus.en || bus.mask == '0) begin
            state_d = ST_IDLE;
            s_d     = s_q;
            frame_d = 1'b0;
            seg_end = 1'b1;
        end

        if (seg_end) dwell_d = '0;

        e_d  = (state_d == ST_SHOW);
        an_d = e_d ? ~(4'b0001 << s_d) : AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= 2'b00;
            e_q     <= 1'b0;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.S     = s_q;
    assign bus.E     = e_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule
